// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED controller: 16-byte register window with a prescaled
// animator (static, blink, rotate-left, rotate-right) driving 8 LED pins.
module led_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned DIV_W     = 24,
    parameter int unsigned DIV_RESET = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic [7:0]  led
);

    typedef enum logic [1:0] {
        ModeStatic = 2'd0,
        ModeBlink  = 2'd1,
        ModeRotl   = 2'd2,
        ModeRotr   = 2'd3
    } mode_e;

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

    logic [7:0]       data_q;
    mode_e            mode_q;
    logic [DIV_W-1:0] div_q;
    logic [15:0]      steps_q;
    logic [DIV_W-1:0] pcnt_q;
    logic [7:0]       shreg_q;
    logic             phase_q;
    logic [31:0]      rdata_q;

    logic [1:0]  reg_sel;
    logic        wr_data;
    logic        wr_mode;
    logic        wr_div;
    logic        wr_pat;
    logic        step;
    logic [31:0] rdata_sel;
    logic        unused_bits;

    assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = mem_addr[3:2];

    assign wr_data = mem_we && hit && (reg_sel == 2'd0);
    assign wr_mode = mem_we && hit && (reg_sel == 2'd1);
    assign wr_div  = mem_we && hit && (reg_sel == 2'd2);
    assign wr_pat  = wr_data || wr_mode;

    // Any effective register write swallows a coincident prescaler step.
    assign step = (pcnt_q == div_q) && !(wr_pat || wr_div);

    assign unused_bits = ^{mem_addr[1:0], mem_wdata};

    always_comb begin
        rdata_sel = '0;
        case (reg_sel)
            2'd0:    rdata_sel = {24'b0, data_q};
            2'd1:    rdata_sel = {30'b0, mode_q};
            2'd2:    rdata_sel = 32'(div_q);
            default: rdata_sel = {16'b0, steps_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            mode_q  <= ModeStatic;
            div_q   <= DIV_INIT;
            steps_q <= '0;
            pcnt_q  <= '0;
            shreg_q <= '0;
            phase_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            if (wr_data) data_q <= mem_wdata[7:0];
            if (wr_mode) mode_q <= mode_e'(mem_wdata[1:0]);
            if (wr_div)  div_q  <= mem_wdata[DIV_W-1:0];

            if (wr_pat || wr_div || step) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + DIV_W'(1);
            end

            if (wr_pat) begin
                // A MODE write reloads the pattern from the current DATA.
                shreg_q <= wr_data ? mem_wdata[7:0] : data_q;
                phase_q <= 1'b1;
                steps_q <= '0;
            end else if (step) begin
                steps_q <= steps_q + 16'd1;
                case (mode_q)
                    ModeBlink: phase_q <= ~phase_q;
                    ModeRotl:  shreg_q <= {shreg_q[6:0], shreg_q[7]};
                    ModeRotr:  shreg_q <= {shreg_q[0], shreg_q[7:1]};
                    default:   ;
                endcase
            end

            rdata_q <= (mem_re && hit) ? rdata_sel : '0;
        end
    end

    always_comb begin
        led = data_q;
        case (mode_q)
            ModeBlink:          led = phase_q ? data_q : 8'h00;
            ModeRotl, ModeRotr: led = shreg_q;
            default:            led = data_q;
        endcase
    end

    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Directed bench for led_mmio_ctrl: a vector table for single-cycle bus
// behaviour plus hand-timed sequences for animation, wrap and reset.
module tb_led_mmio_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        hit;
    logic [7:0]  led;

    int n_cmp  = 0;
    int n_fail = 0;

    led_mmio_ctrl #(
        .BASE_ADDR (BASE),
        .DIV_W     (24),
        .DIV_RESET (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .hit       (hit),
        .led       (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [7:0]  led;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        tick();
        mem_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        mem_re   = 1'b1;
        mem_addr = addr;
        tick();
        mem_re   = 1'b0;
        data     = mem_rdata;
    endtask

    logic [31:0] rd;

    initial begin
        // Starting state for the table: DATA=0, MODE=static, DIV=10.
        vecs[0]  = '{1, 0, BASE + 32'h0,  32'h0000_00A5, 1, 8'hA5, 32'h0};
        vecs[1]  = '{0, 1, BASE + 32'h0,  32'h0,         1, 8'hA5, 32'h0000_00A5};
        vecs[2]  = '{1, 0, BASE + 32'h10, 32'h0000_00FF, 0, 8'hA5, 32'h0};
        vecs[3]  = '{0, 1, BASE + 32'h10, 32'h0,         0, 8'hA5, 32'h0};
        vecs[4]  = '{1, 0, BASE + 32'h4,  32'hFFFF_FFF0, 1, 8'hA5, 32'h0};
        vecs[5]  = '{0, 1, BASE + 32'h4,  32'h0,         1, 8'hA5, 32'h0};
        vecs[6]  = '{1, 0, BASE + 32'h0,  32'h1234_5611, 1, 8'h11, 32'h0};
        vecs[7]  = '{0, 1, BASE + 32'h3,  32'h0,         1, 8'h11, 32'h0000_0011};
        vecs[8]  = '{1, 1, BASE + 32'h0,  32'h0000_0022, 1, 8'h22, 32'h0000_0011};
        vecs[9]  = '{0, 1, BASE + 32'h0,  32'h0,         1, 8'h22, 32'h0000_0022};
        vecs[10] = '{1, 0, BASE + 32'hC,  32'h0000_FFFF, 1, 8'h22, 32'h0};
        vecs[11] = '{0, 1, BASE + 32'hC,  32'h0,         1, 8'h22, 32'h0};
        vecs[12] = '{1, 0, BASE + 32'h8,  32'hFF00_0005, 1, 8'h22, 32'h0};
        vecs[13] = '{0, 1, 32'h0000_0008, 32'h0,         0, 8'h22, 32'h0};

        rst = 1'b1; mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_led", {24'b0, led}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);

        // Reset edge R; this read samples at R+1.
        bus_read(BASE + 32'h8, rd);
        check("reset_div", rd, 32'd10);
        repeat (109) tick();
        bus_read(BASE + 32'hC, rd);
        check("reset_steps_110", rd, 32'd10);

        for (int i = 0; i < 14; i++) begin
            mem_we    = vecs[i].we;
            mem_re    = vecs[i].re;
            mem_addr  = vecs[i].addr;
            mem_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].hit});
            tick();
            mem_we = 1'b0;
            mem_re = 1'b0;
            check($sformatf("vec%0d_led", i), {24'b0, led}, {24'b0, vecs[i].led});
            check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].rdata);
        end
        bus_read(BASE + 32'h8, rd);
        check("div_upper_discard", rd, 32'h0000_0005);

        // Rotate-left with DIV=1: advance every 2 cycles.
        bus_write(BASE + 32'h8, 32'd1);
        bus_write(BASE + 32'h0, 32'h81);
        bus_write(BASE + 32'h4, 32'd2);
        check("rotl_0", {24'b0, led}, 32'h81);
        tick(); check("rotl_1", {24'b0, led}, 32'h81);
        tick(); check("rotl_2", {24'b0, led}, 32'h03);
        tick(); check("rotl_3", {24'b0, led}, 32'h03);
        tick(); check("rotl_4", {24'b0, led}, 32'h06);
        tick();
        // This store lands on a step edge; the reload must win.
        bus_write(BASE + 32'h0, 32'h01);
        check("rotl_reload", {24'b0, led}, 32'h01);
        tick(); check("rotl_reload_hold", {24'b0, led}, 32'h01);
        tick(); check("rotl_reload_step", {24'b0, led}, 32'h02);

        // Blink with DIV=0: toggle every cycle.
        bus_write(BASE + 32'h8, 32'd0);
        bus_write(BASE + 32'h0, 32'hFF);
        bus_write(BASE + 32'h4, 32'd1);
        check("blink_0", {24'b0, led}, 32'hFF);
        tick(); check("blink_1", {24'b0, led}, 32'h00);
        tick(); check("blink_2", {24'b0, led}, 32'hFF);
        tick(); check("blink_3", {24'b0, led}, 32'h00);
        bus_write(BASE + 32'h0, 32'hFF);
        check("blink_store_on_step", {24'b0, led}, 32'hFF);
        bus_read(BASE + 32'hC, rd);
        check("blink_steps_held", rd, 32'h0);
        check("blink_after_store", {24'b0, led}, 32'h00);

        // STEPS wrap: static mode, DIV=0, one step per cycle after edge X.
        bus_write(BASE + 32'h4, 32'd0);
        repeat (65535) tick();
        bus_read(BASE + 32'hC, rd);
        check("steps_ffff", rd, 32'h0000_FFFF);
        bus_read(BASE + 32'hC, rd);
        check("steps_wrap", rd, 32'h0000_0000);

        // Reset wins over a same-cycle store and load.
        bus_write(BASE + 32'h0, 32'h3C);
        check("pre_reset_led", {24'b0, led}, 32'h3C);
        rst = 1'b1; mem_we = 1'b1; mem_re = 1'b1;
        mem_addr = BASE + 32'h0; mem_wdata = 32'h77;
        tick();
        rst = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
        check("rst_store_led", {24'b0, led}, 32'h0);
        check("rst_store_rdata", mem_rdata, 32'h0);
        bus_read(BASE + 32'h0, rd);
        check("rst_data", rd, 32'h0);
        bus_read(BASE + 32'h8, rd);
        check("rst_div", rd, 32'd10);
        bus_read(BASE + 32'h4, rd);
        check("rst_mode", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
